mpu_w8: RTL and testbench
=========================

MPU_W8 -- requirements
Module: mpu_w8

Interface
REQ-001 SHALL have parameter NB, default 14, meaning base data width; data ports are NB+2 bits signed two's complement.
REQ-002 SHALL have parameter HIGH_PREC, default 0: 0 uses the 8-bit constant K=181/256 (10110101b); 1 uses the 17-bit constant K=92677/131072 (10110101000000101b).
REQ-003 SHALL have parameter ROUND, default 0: 0 truncates by arithmetic shift (floor); 1 rounds half-up by adding 2^(F-1) before the shift.
REQ-004 SHALL have port CLK, input, 1, rising-edge clock.
REQ-005 SHALL have port RST_N, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port EI, input, 1, input sample valid.
REQ-007 SHALL have port MODE, input, 2, twiddle select sampled with EI: 0=W0 (x1), 1=W1 ((1-j)K), 2=W2 (-j), 3=W3 ((-1-j)K).
REQ-008 SHALL have port DIR, input, NB+2, real input.
REQ-009 SHALL have port DII, input, NB+2, imaginary input.
REQ-010 SHALL have port EO, output, 1, output valid.
REQ-011 SHALL have port DOR, output, NB+2, real result.
REQ-012 SHALL have port DOI, output, NB+2, imaginary result.
REQ-013 SHALL have port SAT, output, 1, high with EO when either result component was clipped.

Function
REQ-014 SHALL be a fixed 3-stage pipeline: a sample accepted with EI=1 at edge n SHALL appear on DOR/DOI with EO=1 after edge n+3; one sample per cycle is accepted, and there is no back-pressure.
REQ-015 Stage 1 SHALL register MODE and the NB+3-bit sign-extended values s=x+y and d=y-x (x=DIR, y=DII), together with x and y.
REQ-016 Stage 2 SHALL form products by shifts and adds only, with no multiplier primitive: p=s*K and q=d*K at full precision, F=8 or 17 fractional bits.
REQ-017 Mode results SHALL be computed as follows.
- W0: (x, y).
- W1: (q' of s, q' of d), i.e. (sK, dK).
- W2: (y, -x).
- W3: (dK, -sK).
REQ-018 Stage 3 SHALL apply ROUND to the scaled products, then saturate every component to [-2^(NB+1), 2^(NB+1)-1].
REQ-019 SAT SHALL be set for the output sample when any component was clipped; this includes -x with x=-2^(NB+1) in W2.
REQ-020 The valid bit SHALL travel with the data through all stages; stage registers MAY update every cycle.
REQ-021 DOR, DOI and SAT SHALL hold their last valid value while EO=0.
REQ-022 SAT SHALL be 0 whenever EO=0.
REQ-023 MODE and data SHALL be ignored when EI=0.
REQ-024 Back-to-back samples with different MODE values SHALL each use their own MODE; there SHALL be no cross-sample interference.
REQ-025 Rounding SHALL be applied only to the K-scaled paths; W0 and W2 are exact apart from saturation.

Reset
REQ-026 While RST_N=0, all pipeline valid bits SHALL be 0 and EO, SAT, DOR and DOI SHALL be 0, regardless of CLK.
REQ-027 An assertion of RST_N mid-stream SHALL discard every in-flight sample; no EO pulse SHALL come from a sample accepted before the reset.
REQ-028 The first sample accepted on the first edge after RST_N rises SHALL produce EO exactly 3 edges later.

Verification (NB=14, 16-bit data)
REQ-029 HIGH_PREC=0, ROUND=0, MODE=1, DIR=1000, DII=0 -> 3 cycles later DOR=707, DOI=-708, SAT=0; with ROUND=1 -> DOR=707, DOI=-707.
REQ-030 MODE=2, DIR=-32768, DII=5 -> DOR=5, DOI=32767, SAT=1, EO=1 for exactly one cycle.
REQ-031 MODE=1, DIR=DII=32767 -> DOR=32767 (clipped from 46334), DOI=0, SAT=1.
REQ-032 Burst of 4 consecutive samples with MODE 0,1,2,3 and DIR=DII=256 (HIGH_PREC=0, ROUND=0) -> 4 consecutive EO cycles giving (256,256), (362,0), (256,-256), (0,-362).
REQ-033 Pulse RST_N low for 1 cycle, asynchronously, while 2 samples are in flight -> EO stays 0 and outputs are 0; a new sample after release appears 3 edges later.
REQ-034 Random-vector sweep in all modes for both HIGH_PREC settings against a bit-accurate model -> exact match on DOR, DOI and SAT.

Source files
------------

// File: rtl/mpu_w8_if.sv
// mpu_w8_if -- sample bus for the W8 twiddle multiplier.
//   EI/MODE/DIR/DII : input sample valid, twiddle select, real and imaginary data
//   EO/DOR/DOI/SAT  : output valid, real and imaginary result, clip flag
// master drives the inputs and observes the results; slave is the multiplier side.
interface mpu_w8_if #(
  parameter int NB = 14
);
  logic                 EI;
  logic [1:0]           MODE;
  logic signed [NB+1:0] DIR;
  logic signed [NB+1:0] DII;
  logic                 EO;
  logic signed [NB+1:0] DOR;
  logic signed [NB+1:0] DOI;
  logic                 SAT;

  modport master (output EI, MODE, DIR, DII, input EO, DOR, DOI, SAT);
  modport slave  (input EI, MODE, DIR, DII, output EO, DOR, DOI, SAT);
endinterface

// File: rtl/mpu_w8.sv
// mpu_w8 -- multiply a complex sample by one of the four radix-8 twiddles
// W0 = 1, W1 = (1-j)K, W2 = -j, W3 = (-1-j)K with K ~ 1/sqrt(2).
// Fixed pipeline, one sample per cycle, no back-pressure; a sample captured at
// edge n is presented with EO=1 after edge n+3.
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset, clears every valid bit and the outputs
//   bus   : slave side of mpu_w8_if (EI, MODE, DIR, DII in; EO, DOR, DOI, SAT out)
// Parameters: NB (data is NB+2 bits), HIGH_PREC (8- or 17-bit K),
// ROUND (0 floor, 1 round half-up on the K-scaled paths only).
module mpu_w8 #(
  parameter int NB        = 14,
  parameter int HIGH_PREC = 0,
  parameter int ROUND     = 0
) (
  input  logic         CLK,
  input  logic         RST_N,
  mpu_w8_if.slave      bus
);
  localparam int W  = NB + 2;                    // data width
  localparam int WS = NB + 3;                    // sum/difference width
  localparam int F  = (HIGH_PREC != 0) ? 17 : 8; // fractional bits of K
  // Product width: |s*K| < 2^(NB+2+F); one extra bit so -s*K cannot overflow.
  localparam int WP = NB + 4 + F;

  localparam logic [16:0] K = (HIGH_PREC != 0) ? 17'b1_0110_1010_0000_0101 : 17'd181;
  localparam logic signed [WP-1:0] HALF = (ROUND != 0) ? (WP'(1) <<< (F - 1)) : '0;
  localparam logic signed [WP-1:0] MAXV = {{(F + 3){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [WP-1:0] MINV = {{(F + 3){1'b1}}, {(W - 1){1'b0}}};

  // ---------------- stage 1: capture, s = x + y, d = y - x ----------------
  logic                 v1_reg;
  logic [1:0]           mode1_reg;
  logic signed [W-1:0]  x1_reg, y1_reg;
  logic signed [WS-1:0] s1_reg, d1_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1_reg    <= 1'b0;
      mode1_reg <= '0;
      x1_reg    <= '0;
      y1_reg    <= '0;
      s1_reg    <= '0;
      d1_reg    <= '0;
    end else begin
      v1_reg <= bus.EI;
      if (bus.EI) begin
        mode1_reg <= bus.MODE;
        x1_reg    <= bus.DIR;
        y1_reg    <= bus.DII;
        s1_reg    <= {bus.DIR[W-1], bus.DIR} + {bus.DII[W-1], bus.DII};
        d1_reg    <= {bus.DII[W-1], bus.DII} - {bus.DIR[W-1], bus.DIR};
      end
    end
  end

  // ---------------- stage 2: shift-and-add products p = s*K, q = d*K ----------------
  logic signed [WP-1:0] s_ext, d_ext;
  logic signed [WP-1:0] p_sum, q_sum;

  assign s_ext = WP'(s1_reg);
  assign d_ext = WP'(d1_reg);

  // K is a constant, so only its set bits leave adders behind.
  always_comb begin
    p_sum = '0;
    q_sum = '0;
    for (int i = 0; i < 17; i++) begin
      if (K[i]) begin
        p_sum = p_sum + (s_ext <<< i);
        q_sum = q_sum + (d_ext <<< i);
      end
    end
  end

  logic                 v2_reg;
  logic [1:0]           mode2_reg;
  logic signed [W-1:0]  x2_reg, y2_reg;
  logic signed [WP-1:0] p2_reg, q2_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v2_reg    <= 1'b0;
      mode2_reg <= '0;
      x2_reg    <= '0;
      y2_reg    <= '0;
      p2_reg    <= '0;
      q2_reg    <= '0;
    end else begin
      v2_reg    <= v1_reg;
      mode2_reg <= mode1_reg;
      x2_reg    <= x1_reg;
      y2_reg    <= y1_reg;
      p2_reg    <= p_sum;
      q2_reg    <= q_sum;
    end
  end

  // ---------------- stage 3: mode select, round, saturate ----------------
  // Lane 0 is the real result, lane 1 the imaginary. A lane is either an exact
  // integer (W0/W2) or a K-scaled product that still carries F fraction bits.
  logic signed [WP-1:0] x_ext2, y_ext2;
  logic signed [WP-1:0] lane_raw    [2];
  logic                 lane_scaled [2];
  logic [W-1:0]         lane_out    [2];
  logic                 lane_clip   [2];

  assign x_ext2 = WP'(x2_reg);
  assign y_ext2 = WP'(y2_reg);

  always_comb begin
    lane_raw[0]    = '0;
    lane_raw[1]    = '0;
    lane_scaled[0] = 1'b0;
    lane_scaled[1] = 1'b0;
    case (mode2_reg)
      2'd0: begin
        lane_raw[0] = x_ext2;
        lane_raw[1] = y_ext2;
      end
      2'd1: begin
        lane_raw[0]    = p2_reg;
        lane_raw[1]    = q2_reg;
        lane_scaled[0] = 1'b1;
        lane_scaled[1] = 1'b1;
      end
      2'd2: begin
        lane_raw[0] = y_ext2;
        lane_raw[1] = -x_ext2;   // -(-2^(NB+1)) lands outside range and clips
      end
      default: begin
        // -sK is negated at full precision, so rounding sees the true value.
        lane_raw[0]    = q2_reg;
        lane_raw[1]    = -p2_reg;
        lane_scaled[0] = 1'b1;
        lane_scaled[1] = 1'b1;
      end
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic signed [WP-1:0] adj;
    logic signed [WP-1:0] val;
    assign adj = lane_raw[gi] + (lane_scaled[gi] ? HALF : '0);
    assign val = lane_scaled[gi] ? (adj >>> F) : lane_raw[gi];
    assign lane_clip[gi] = (val > MAXV) || (val < MINV);
    assign lane_out[gi]  = (val > MAXV) ? MAXV[W-1:0] :
                           (val < MINV) ? MINV[W-1:0] : val[W-1:0];
  end

  logic                v3_reg;
  logic signed [W-1:0] r3_reg, i3_reg;
  logic                sat3_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v3_reg   <= 1'b0;
      r3_reg   <= '0;
      i3_reg   <= '0;
      sat3_reg <= 1'b0;
    end else begin
      v3_reg   <= v2_reg;
      r3_reg   <= lane_out[0];
      i3_reg   <= lane_out[1];
      sat3_reg <= lane_clip[0] | lane_clip[1];
    end
  end

  // ---------------- output register ----------------
  // Data holds its last valid value between samples; SAT only accompanies EO.
  logic                eo_reg;
  logic signed [W-1:0] dor_reg, doi_reg;
  logic                sat_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      eo_reg  <= 1'b0;
      dor_reg <= '0;
      doi_reg <= '0;
      sat_reg <= 1'b0;
    end else begin
      eo_reg  <= v3_reg;
      sat_reg <= v3_reg & sat3_reg;
      if (v3_reg) begin
        dor_reg <= r3_reg;
        doi_reg <= i3_reg;
      end
    end
  end

  assign bus.EO  = eo_reg;
  assign bus.DOR = dor_reg;
  assign bus.DOI = doi_reg;
  assign bus.SAT = sat_reg;
endmodule

// File: tb/tb_mpu_w8.sv
// tb_mpu_w8 -- scoreboard bench for mpu_w8. Four instances cover every
// HIGH_PREC x ROUND combination and share one stimulus stream. Directed rows
// carry hand-computed results per configuration; random rows use a reference
// model. Each instance has a feeder (pushes expectations when a sample is
// accepted) and a monitor (pops and compares on EO, checks hold/reset otherwise).
module tb_mpu_w8;
  localparam int NB = 14;
  localparam int W  = NB + 2;
  localparam int ND = 13;

  typedef struct {
    int r;
    int i;
    bit s;
    int c;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                ei;
  logic [1:0]          mode;
  logic signed [W-1:0] dir, dii;
  logic [3:0]          hmask;
  int                  hr [4];
  int                  hi [4];
  bit                  hs [4];
  int                  cyc = 0;
  int                  n_vec = 0;
  int                  n_err = 0;
  event                drain_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Columns: mode, x, y, r[cfg0..3], i[cfg0..3], sat[cfg0..3], idle-after.
  // cfg = 2*HIGH_PREC + ROUND.
  int tab [ND][16] = '{
    '{1, 1000, 0,        707, 707, 707, 707,          -708, -707, -708, -707,       0, 0, 0, 0, 1},
    '{2, -32768, 5,      5, 5, 5, 5,                  32767, 32767, 32767, 32767,   1, 1, 1, 1, 1},
    '{1, 32767, 32767,   32767, 32767, 32767, 32767,  0, 0, 0, 0,                   1, 1, 1, 1, 1},
    '{0, 256, 256,       256, 256, 256, 256,          256, 256, 256, 256,           0, 0, 0, 0, 0},
    '{1, 256, 256,       362, 362, 362, 362,          0, 0, 0, 0,                   0, 0, 0, 0, 0},
    '{2, 256, 256,       256, 256, 256, 256,          -256, -256, -256, -256,       0, 0, 0, 0, 0},
    '{3, 256, 256,       0, 0, 0, 0,                  -362, -362, -363, -362,       0, 0, 0, 0, 1},
    '{3, 1000, 0,        -708, -707, -708, -707,      -708, -707, -708, -707,       0, 0, 0, 0, 1},
    '{3, -32768, 32767,  32767, 32767, 32767, 32767,  0, 1, 0, 1,                   1, 1, 1, 1, 1},
    '{1, -32768, -32768, -32768, -32768, -32768, -32768, 0, 0, 0, 0,                1, 1, 1, 1, 1},
    '{0, -32768, 32767,  -32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767, 0, 0, 0, 0, 0},
    '{2, 100, -32768,    -32768, -32768, -32768, -32768, -100, -100, -100, -100,    0, 0, 0, 0, 0},
    '{1, 1, 0,           0, 1, 0, 1,                  -1, -1, -1, -1,               0, 0, 0, 0, 1}
  };

  function automatic longint scale(input longint v, input int f, input int rd);
    longint t;
    t = v + ((rd != 0) ? (longint'(1) <<< (f - 1)) : 0);
    return t >>> f;
  endfunction

  function automatic void clip(input longint v, output int o, output bit c);
    longint lim;
    lim = longint'(1) <<< (NB + 1);
    c = 1'b0;
    if (v > lim - 1) begin o = int'(lim - 1); c = 1'b1; end
    else if (v < -lim) begin o = int'(-lim); c = 1'b1; end
    else o = int'(v);
  endfunction

  function automatic void model(input int hp, input int rd, input int m, input int x, input int y,
                                output int r, output int i, output bit s);
    longint k, sm, df, vr, vi;
    int f;
    bit cr, ci;
    f  = (hp != 0) ? 17 : 8;
    k  = (hp != 0) ? 92677 : 181;
    sm = longint'(x) + longint'(y);
    df = longint'(y) - longint'(x);
    case (m)
      0:       begin vr = x;                     vi = y; end
      1:       begin vr = scale(sm * k, f, rd);  vi = scale(df * k, f, rd); end
      2:       begin vr = y;                     vi = -longint'(x); end
      default: begin vr = scale(df * k, f, rd);  vi = scale(-(sm * k), f, rd); end
    endcase
    clip(vr, r, cr);
    clip(vi, i, ci);
    s = cr | ci;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int HP = gi / 2;
    localparam int RD = gi % 2;

    mpu_w8_if #(.NB(NB)) bus ();
    assign bus.EI   = ei;
    assign bus.MODE = mode;
    assign bus.DIR  = dir;
    assign bus.DII  = dii;

    mpu_w8 #(.NB(NB), .HIGH_PREC(HP), .ROUND(RD)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
    );

    exp_t exp_q [$];

    // Feeder: expectation for every sample the DUT accepts at this edge.
    initial begin
      exp_t e;
      forever begin
        @(posedge clk);
        if (rst_n === 1'b1 && ei === 1'b1) begin
          if (hmask[gi]) begin
            e.r = hr[gi];
            e.i = hi[gi];
            e.s = hs[gi];
          end else begin
            model(HP, RD, int'(mode), int'(dir), int'(dii), e.r, e.i, e.s);
          end
          e.c = cyc + 4;
          exp_q.push_back(e);
        end
      end
    end

    // Reset discards everything in flight.
    always @(negedge rst_n) exp_q.delete();

    // Monitor
    initial begin
      exp_t e;
      int lr, li;
      lr = 0;
      li = 0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          n_vec++;
          if (bus.EO !== 1'b0 || bus.DOR !== 0 || bus.DOI !== 0 || bus.SAT !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state cfg%0d: got eo=%0b r=%0d i=%0d sat=%0b, required all 0",
                     gi, bus.EO, bus.DOR, bus.DOI, bus.SAT);
          end
          lr = 0;
          li = 0;
        end else if (bus.EO === 1'b1) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_eo cfg%0d: got EO=1 at cycle %0d, required no output", gi, cyc);
          end else begin
            e = exp_q.pop_front();
            if (int'(bus.DOR) != e.r || int'(bus.DOI) != e.i || bus.SAT !== e.s || cyc != e.c) begin
              n_err++;
              $display("FAIL result cfg%0d: got r=%0d i=%0d sat=%0b cyc=%0d, required r=%0d i=%0d sat=%0b cyc=%0d",
                       gi, bus.DOR, bus.DOI, bus.SAT, cyc, e.r, e.i, e.s, e.c);
            end
          end
          lr = int'(bus.DOR);
          li = int'(bus.DOI);
        end else begin
          n_vec++;
          if (int'(bus.DOR) != lr || int'(bus.DOI) != li || bus.SAT !== 1'b0 || bus.EO !== 1'b0) begin
            n_err++;
            $display("FAIL hold cfg%0d: got eo=%0b r=%0d i=%0d sat=%0b, required eo=0 r=%0d i=%0d sat=0",
                     gi, bus.EO, bus.DOR, bus.DOI, bus.SAT, lr, li);
          end
        end
      end
    end

    initial begin
      @(drain_ev);
      n_vec++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL drain cfg%0d: %0d outputs never appeared, required 0", gi, exp_q.size());
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    ei   = 1'b0;
    mode = 2'($urandom_range(0, 3));
    dir  = W'($urandom);
    dii  = W'($urandom);
  endtask

  task automatic issue_row(input int v);
    @(negedge clk);
    ei    = 1'b1;
    mode  = 2'(tab[v][0]);
    dir   = W'(tab[v][1]);
    dii   = W'(tab[v][2]);
    hmask = 4'hF;
    for (int c = 0; c < 4; c++) begin
      hr[c] = tab[v][3 + c];
      hi[c] = tab[v][7 + c];
      hs[c] = (tab[v][11 + c] != 0);
    end
  endtask

  task automatic issue_model(input int m, input int x, input int y);
    @(negedge clk);
    ei    = 1'b1;
    mode  = 2'(m);
    dir   = W'(x);
    dii   = W'(y);
    hmask = 4'h0;
  endtask

  initial begin
    ei    = 1'b0;
    mode  = '0;
    dir   = '0;
    dii   = '0;
    hmask = '0;
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      hr[c] = 0;
      hi[c] = 0;
      hs[c] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Directed rows with hand-computed results.
    for (int v = 0; v < ND; v++) begin
      issue_row(v);
      if (tab[v][15] != 0) idle();
    end
    repeat (4) idle();

    // Random sweep, all modes, with occasional idle cycles carrying garbage.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      issue_model(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768);
    end
    repeat (6) idle();

    // Asynchronous reset pulse with two samples in flight.
    issue_model(1, 1234, -567);
    issue_model(3, -4000, 999);
    @(negedge clk);
    ei = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    // Present the next sample while still in reset so it is taken on the
    // first edge after release.
    ei    = 1'b1;
    mode  = 2'd1;
    dir   = W'(1000);
    dii   = W'(0);
    hmask = 4'hF;
    hr = '{707, 707, 707, 707};
    hi = '{-708, -707, -708, -707};
    hs = '{1'b0, 1'b0, 1'b0, 1'b0};
    #2 rst_n = 1'b1;
    repeat (8) idle();

    ->drain_ev;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
